synth_envelope_pwm: RTL and testbench

- Output stage directly downstream of pocket_synth: consumes its square-wave audio_out and a key-gate, applies an ADSR amplitude envelope, drives the speaker pin as PWM.
- Replaces the raw 0/1 square wave with a click-free note whose loudness ramps on press and fades on release.
- Sits between the synth core and the board audio pin; one clock domain.

---
 rtl/synth_pkg.sv | 16 +
 rtl/sync_2ff.sv | 31 +++
 rtl/synth_envelope_pwm.sv | 180 ++++++++++++++++++
 tb/tb_synth_envelope_pwm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the pocket_synth output stage.
// Holds the envelope state codes (also reused by the synth LED logic)
// and the default envelope/PWM resolution.
package synth_pkg;

   localparam int unsigned LEVEL_W_DEFAULT = 8;

   typedef enum logic [2:0] {
      ENV_IDLE    = 3'd0,
      ENV_ATTACK  = 3'd1,
      ENV_DECAY   = 3'd2,
      ENV_SUSTAIN = 3'd3,
      ENV_RELEASE = 3'd4
   } env_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bundle of independent asynchronous levels.
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous active-high reset, clears both stages
//   d_i    asynchronous inputs
//   q_o    synchronized outputs (two clk edges of latency)
module sync_2ff #(
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/synth_envelope_pwm.sv
// ADSR envelope and PWM output stage for the pocket_synth square wave.
// The key gate drives an attack/decay/sustain/release level ramp; the
// level sets the PWM duty applied while the tone is high.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   tone_in  square wave from the synth core (asynchronous)
//   gate     key-held level (asynchronous, may bounce)
//   pwm_out  registered PWM audio to the pin
//   level    current envelope level
//   active   high whenever the envelope is not idle
//   state    encoded envelope state for debug/LEDs
module synth_envelope_pwm
   import synth_pkg::*;
#(
   parameter int unsigned LEVEL_W       = LEVEL_W_DEFAULT,
   parameter int unsigned ATTACK_STEP   = 94,
   parameter int unsigned DECAY_STEP    = 188,
   parameter int unsigned RELEASE_STEP  = 2353,
   parameter int unsigned SUSTAIN_LEVEL = 160
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tone_in,
   input  logic               gate,
   output logic               pwm_out,
   output logic [LEVEL_W-1:0] level,
   output logic               active,
   output logic [2:0]         state
);

   localparam int unsigned MaxAD   = (ATTACK_STEP > DECAY_STEP) ? ATTACK_STEP : DECAY_STEP;
   localparam int unsigned MaxStep = (MaxAD > RELEASE_STEP) ? MaxAD : RELEASE_STEP;
   localparam int unsigned PrescW  = $clog2(MaxStep + 1);

   localparam logic [LEVEL_W-1:0] LevelMax   = '1;
   localparam logic [LEVEL_W-1:0] LevelMaxM1 = LevelMax - 1'b1;
   localparam logic [LEVEL_W-1:0] SusLvl     = LEVEL_W'(SUSTAIN_LEVEL);
   localparam logic [LEVEL_W-1:0] SusLvlP1   = SusLvl + 1'b1;
   localparam logic [LEVEL_W-1:0] LevelOne   = LEVEL_W'(1);

   logic [1:0] sync_q;
   logic       tone_s;
   logic       gate_s;

   sync_2ff #(
      .Width(2)
   ) u_sync (
      .clk_i(clk),
      .rst_i(rst),
      .d_i  ({tone_in, gate}),
      .q_o  (sync_q)
   );

   assign tone_s = sync_q[1];
   assign gate_s = sync_q[0];

   env_state_e         state_q, state_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [PrescW-1:0]  presc_q, presc_d;
   logic [LEVEL_W-1:0] pwm_cnt_q;
   logic               pwm_q;
   logic               gate_d_q;
   logic [1:0]         settle_q;
   logic               armed_q;

   // The sync stages reset to 0, so a gate already high at reset release
   // would look like a rising edge. Only arm edge detection once a real
   // pin sample (pipeline filled) has been seen low.
   logic gate_valid;
   logic gate_rise;
   assign gate_valid = (settle_q == 2'd2);
   assign gate_rise  = gate_s & ~gate_d_q & armed_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ENV_IDLE;
         level_q   <= '0;
         presc_q   <= '0;
         pwm_cnt_q <= '0;
         pwm_q     <= 1'b0;
         gate_d_q  <= 1'b0;
         settle_q  <= 2'd0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         pwm_q     <= tone_s & (pwm_cnt_q < level_q);
         gate_d_q  <= gate_s;
         if (!gate_valid) settle_q <= settle_q + 2'd1;
         armed_q   <= armed_q | (gate_valid & ~gate_s);
      end
   end

   logic [PrescW-1:0] step_last;
   logic              tick;

   always_comb begin
      step_last = '0;
      case (state_q)
         ENV_ATTACK:  step_last = PrescW'(ATTACK_STEP - 1);
         ENV_DECAY:   step_last = PrescW'(DECAY_STEP - 1);
         ENV_RELEASE: step_last = PrescW'(RELEASE_STEP - 1);
         default:     step_last = '0;
      endcase
   end

   assign tick = (presc_q == step_last);

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      presc_d = presc_q;
      if (gate_rise) begin
         // Retrigger keeps the current level.
         state_d = ENV_ATTACK;
         presc_d = '0;
      end else if (!gate_s &&
                   (state_q inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN})) begin
         state_d = ENV_RELEASE;
         presc_d = '0;
      end else begin
         case (state_q)
            ENV_ATTACK: begin
               if (tick) begin
                  presc_d = '0;
                  // >= also covers a retrigger that starts at full scale.
                  if (level_q >= LevelMaxM1) begin
                     level_d = LevelMax;
                     state_d = ENV_DECAY;
                  end else begin
                     level_d = level_q + 1'b1;
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            ENV_DECAY: begin
               if (tick) begin
                  presc_d = '0;
                  if (level_q <= SusLvlP1) begin
                     level_d = SusLvl;
                     state_d = ENV_SUSTAIN;
                  end else begin
                     level_d = level_q - 1'b1;
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            ENV_RELEASE: begin
               if (tick) begin
                  presc_d = '0;
                  if (level_q <= LevelOne) begin
                     level_d = '0;
                     state_d = ENV_IDLE;
                  end else begin
                     level_d = level_q - 1'b1;
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            ENV_IDLE, ENV_SUSTAIN: presc_d = '0;
            default: begin
               state_d = ENV_IDLE;
               presc_d = '0;
            end
         endcase
      end
   end

   assign pwm_out = pwm_q;
   assign level   = level_q;
   assign state   = state_q;
   assign active  = (state_q != ENV_IDLE);

endmodule

// File: tb/tb_synth_envelope_pwm.sv
// Directed bench for synth_envelope_pwm with short step values.
module tb_synth_envelope_pwm;

   logic       clk;
   logic       rst;
   logic       tone_in;
   logic       gate;
   logic       pwm_out;
   logic [7:0] level;
   logic       active;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   synth_envelope_pwm #(
      .LEVEL_W      (8),
      .ATTACK_STEP  (4),
      .DECAY_STEP   (2),
      .RELEASE_STEP (8),
      .SUSTAIN_LEVEL(128)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .tone_in(tone_in),
      .gate   (gate),
      .pwm_out(pwm_out),
      .level  (level),
      .active (active),
      .state  (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic count_pwm(output int highs);
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         tick(1);
         if (pwm_out === 1'b1) highs++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; gate = 1'b0; tone_in = 1'b1;
      tick(3);
      n_tests++;
      if (state !== 3'd0) begin $display("FAIL reset_state: got %0d want 0", state); n_fail++; end
      n_tests++;
      if (level !== 8'd0) begin $display("FAIL reset_level: got %0d want 0", level); n_fail++; end
      n_tests++;
      if (pwm_out !== 1'b0) begin $display("FAIL reset_pwm: got %b want 0", pwm_out); n_fail++; end
      n_tests++;
      if (active !== 1'b0) begin $display("FAIL reset_active: got %b want 0", active); n_fail++; end
      rst = 1'b0;
      tick(6);
   endtask

   task automatic test_attack;
      gate = 1'b1;
      tick(2);
      n_tests++;
      if (state !== 3'd0) begin $display("FAIL gate_lat_early: got %0d want 0", state); n_fail++; end
      tick(1);
      n_tests++;
      if (state !== 3'd1) begin $display("FAIL gate_lat_attack: got %0d want 1", state); n_fail++; end
      n_tests++;
      if (active !== 1'b1) begin $display("FAIL attack_active: got %b want 1", active); n_fail++; end
      tick(3);
      n_tests++;
      if (level !== 8'd0) begin $display("FAIL attack_pre_step: got %0d want 0", level); n_fail++; end
      tick(1);
      n_tests++;
      if (level !== 8'd1) begin $display("FAIL attack_first_step: got %0d want 1", level); n_fail++; end
      tick(1015);
      n_tests++;
      if (level !== 8'd254 || state !== 3'd1) begin
         $display("FAIL attack_254: got level %0d state %0d want 254/1", level, state); n_fail++;
      end
      tick(1);
      n_tests++;
      if (level !== 8'd255 || state !== 3'd2) begin
         $display("FAIL attack_top: got level %0d state %0d want 255/2", level, state); n_fail++;
      end
   endtask

   task automatic test_decay_sustain_pwm;
      int highs;
      tick(253);
      n_tests++;
      if (level !== 8'd129 || state !== 3'd2) begin
         $display("FAIL decay_129: got level %0d state %0d want 129/2", level, state); n_fail++;
      end
      tick(1);
      n_tests++;
      if (level !== 8'd128 || state !== 3'd3) begin
         $display("FAIL decay_sustain: got level %0d state %0d want 128/3", level, state); n_fail++;
      end
      count_pwm(highs);
      n_tests++;
      if (highs !== 128) begin $display("FAIL pwm_duty_128: got %0d want 128", highs); n_fail++; end
      tone_in = 1'b0;
      tick(4);
      count_pwm(highs);
      n_tests++;
      if (highs !== 0) begin $display("FAIL pwm_tone_low: got %0d want 0", highs); n_fail++; end
      tone_in = 1'b1;
      tick(4);
      count_pwm(highs);
      n_tests++;
      if (highs !== 128) begin $display("FAIL pwm_tone_back: got %0d want 128", highs); n_fail++; end
      tick(10000);
      n_tests++;
      if (level !== 8'd128 || state !== 3'd3) begin
         $display("FAIL sustain_hold: got level %0d state %0d want 128/3", level, state); n_fail++;
      end
   endtask

   task automatic test_release;
      int highs;
      gate = 1'b0;
      tick(2);
      n_tests++;
      if (state !== 3'd3) begin $display("FAIL rel_lat_early: got %0d want 3", state); n_fail++; end
      tick(1);
      n_tests++;
      if (state !== 3'd4 || level !== 8'd128) begin
         $display("FAIL rel_enter: got state %0d level %0d want 4/128", state, level); n_fail++;
      end
      tick(1023);
      n_tests++;
      if (level !== 8'd1 || state !== 3'd4) begin
         $display("FAIL rel_level1: got level %0d state %0d want 1/4", level, state); n_fail++;
      end
      tick(1);
      n_tests++;
      if (level !== 8'd0 || state !== 3'd0 || active !== 1'b0) begin
         $display("FAIL rel_idle: got level %0d state %0d active %b want 0/0/0",
                  level, state, active);
         n_fail++;
      end
      count_pwm(highs);
      n_tests++;
      if (highs !== 0) begin $display("FAIL pwm_level0: got %0d want 0", highs); n_fail++; end
   endtask

   task automatic test_retrigger;
      gate = 1'b1;
      tick(3);
      n_tests++;
      if (state !== 3'd1) begin $display("FAIL retrig_attack: got %0d want 1", state); n_fail++; end
      // Level reaches 60 at 240 clocks into ATTACK; release lands one edge later.
      tick(238);
      gate = 1'b0;
      tick(3);
      n_tests++;
      if (state !== 3'd4 || level !== 8'd60) begin
         $display("FAIL retrig_release: got state %0d level %0d want 4/60", state, level); n_fail++;
      end
      tick(158);
      gate = 1'b1;
      tick(2);
      n_tests++;
      if (state !== 3'd4 || level !== 8'd40) begin
         $display("FAIL retrig_rel40: got state %0d level %0d want 4/40", state, level); n_fail++;
      end
      tick(1);
      n_tests++;
      if (state !== 3'd1 || level !== 8'd40) begin
         $display("FAIL retrig_keep: got state %0d level %0d want 1/40", state, level); n_fail++;
      end
      tick(859);
      n_tests++;
      if (level !== 8'd254 || state !== 3'd1) begin
         $display("FAIL retrig_254: got level %0d state %0d want 254/1", level, state); n_fail++;
      end
      tick(1);
      n_tests++;
      if (level !== 8'd255 || state !== 3'd2) begin
         $display("FAIL retrig_top: got level %0d state %0d want 255/2", level, state); n_fail++;
      end
   endtask

   task automatic test_reset_mid_note;
      tick(110);
      n_tests++;
      if (level !== 8'd200 || state !== 3'd2) begin
         $display("FAIL mid_decay_200: got level %0d state %0d want 200/2", level, state); n_fail++;
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (level !== 8'd0 || state !== 3'd0 || pwm_out !== 1'b0) begin
         $display("FAIL async_reset: got level %0d state %0d pwm %b want 0/0/0",
                  level, state, pwm_out);
         n_fail++;
      end
      tick(3);
      rst = 1'b0;
      tick(20);
      n_tests++;
      if (state !== 3'd0 || level !== 8'd0) begin
         $display("FAIL no_trig_after_reset: got state %0d level %0d want 0/0", state, level);
         n_fail++;
      end
      gate = 1'b0;
      tick(4);
   endtask

   initial begin
      test_reset();
      test_attack();
      test_decay_sustain_pwm();
      test_release();
      test_retrigger();
      test_reset_mid_note();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
